ppm_encoder: RTL
================

PPM_ENCODER -- requirements
Module: ppm_encoder

Interface
REQ-001 SHALL expose parameters: CLK_PER_US, default 38, sys_clk cycles per microsecond tick; FRAME_US, default 20000, frame period in us; SEP_US, default 300, separator low time in us.
REQ-002 sys_clk  input  1  system clock, 38 MHz nominal.
REQ-003 resetn  input  1  reset; synchronous, active-low; clock sys_clk.
REQ-004 enable  input  1  start/continue frame generation.
REQ-005 upd  input  1  one-cycle strobe; loads ch0_val..ch3_val into shadow registers.
REQ-006 ch0_val, ch1_val, ch2_val, ch3_val  input  8 each  channel rates, 0-255.
REQ-007 ppm_out  output  1  PPM stream; idle level high.
REQ-008 frame_start  output  1  one-cycle pulse on entry to each frame.
REQ-009 busy  output  1  high while a frame is in progress.
REQ-010 ch_idx  output  2  index of the channel slot being sent.

Function
REQ-011 The us tick prescaler SHALL count 0..CLK_PER_US-1 and assert the tick when it reaches CLK_PER_US-1; it SHALL clear to 0 on frame entry.
REQ-012 Shadow registers SHALL capture all four channel inputs on the cycle upd=1.
REQ-013 Active registers SHALL copy from the shadow registers on frame entry only. If upd and frame entry coincide, the new values SHALL be used.
REQ-014 Slot width in us SHALL be 1000 + 4*val (11-bit result, range 1000..2020).
REQ-015 FSM states: IDLE, SEP, MARK, TAIL, GAP.
REQ-016 IDLE->SEP when enable=1. This transition is frame entry: frame_start=1 for that cycle, ch_idx=0, frame counter cleared.
REQ-017 SEP: ppm_out=0 for SEP_US ticks, then go to MARK.
REQ-018 MARK: ppm_out=1 for (slot width - SEP_US) ticks. On completion, if ch_idx<3, increment ch_idx and go to SEP; otherwise go to TAIL.
REQ-019 TAIL: ppm_out=0 for SEP_US ticks, then go to GAP.
REQ-020 GAP: ppm_out=1 until the frame counter reaches FRAME_US ticks. Then go to SEP with frame entry if enable=1, else go to IDLE.
REQ-021 Frame counter: 15-bit, counts ticks from frame entry; frame length SHALL be exactly FRAME_US ticks for all values.
REQ-022 enable deassert mid-frame SHALL NOT truncate the frame; enable is sampled only at the IDLE and GAP exits.
REQ-023 busy SHALL be 1 in SEP, MARK, TAIL, GAP and 0 in IDLE.

Reset
REQ-024 While resetn=0 on a sys_clk edge: state=IDLE, ppm_out=1, frame_start=0, busy=0, ch_idx=0, prescaler=0, frame counter=0.
REQ-025 While resetn=0: shadow and active registers cleared to 0.
REQ-026 Reset mid-frame SHALL abort the frame immediately with no further pulses until enable is sampled after release.

Configuration
REQ-027 Macro PPM_INVERT_EN, when defined, SHALL invert ppm_out in all states and in reset (idle low, separators high); when undefined, polarity is as stated above.

Verification
REQ-028 Reset, then enable=1 with all values 0 -> frame_start pulse; four 300 us low / 700 us high slots; 300 us low tail; ppm_out high until 20000 us; next frame_start exactly 20000 us after the first.
REQ-029 Values 255,128,64,0 loaded via upd before enable -> high times 1720, 1212, 956, 700 us; slot periods 2020, 1512, 1256, 1000 us.
REQ-030 upd with new values during ch1 MARK -> current frame unchanged; new values appear from the next frame_start.
REQ-031 enable dropped during ch2 -> frame completes to 20000 us; then IDLE, busy=0, ppm_out=1, no further frame_start.
REQ-032 resetn=0 asserted during MARK -> next cycle ppm_out=1, busy=0, ch_idx=0.
REQ-033 Build with PPM_INVERT_EN -> same timing as REQ-028 with all ppm_out levels inverted, and reset level 0.

Source files
------------

// File: rtl/ppm_encoder.sv
// ppm_encoder: four-channel PPM frame generator.
//
// Each frame starts with frame_start, then sends four channel slots. A slot is
// a separator low of SEP_US followed by a mark high, and lasts 1000 + 4*val us
// in total. After the fourth slot comes a separator-length low tail, then the
// line idles high until FRAME_US has elapsed since frame entry. Timing is
// counted in microsecond ticks derived from sys_clk by a CLK_PER_US prescaler.
//
// Ports:
//   sys_clk              system clock
//   resetn               synchronous active-low reset
//   enable               start/continue frames (sampled at IDLE and GAP exits)
//   upd                  one-cycle strobe loading ch*_val into shadow registers
//   ch0_val..ch3_val     channel values 0..255
//   ppm_out              PPM stream (idle high)
//   frame_start          one-cycle pulse on frame entry
//   busy                 high while a frame is in progress
//   ch_idx               channel slot currently being sent
//
// Build option: define PPM_INVERT_EN to invert ppm_out everywhere, including
// in reset (idle low, separators high).

module ppm_encoder #(
  parameter int unsigned CLK_PER_US = 38,
  parameter int unsigned FRAME_US   = 20000,
  parameter int unsigned SEP_US     = 300
) (
  input  logic       sys_clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       upd,
  input  logic [7:0] ch0_val,
  input  logic [7:0] ch1_val,
  input  logic [7:0] ch2_val,
  input  logic [7:0] ch3_val,
  output logic       ppm_out,
  output logic       frame_start,
  output logic       busy,
  output logic [1:0] ch_idx
);

  localparam int unsigned PW = $clog2(CLK_PER_US + 1);
  localparam int unsigned FW = 15;
  localparam int unsigned CW = 16;
  localparam int unsigned SW = 11;

`ifdef PPM_INVERT_EN
  localparam logic LVL_HI = 1'b0;
`else
  localparam logic LVL_HI = 1'b1;
`endif
  localparam logic LVL_LO = ~LVL_HI;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEP,
    S_MARK,
    S_TAIL,
    S_GAP
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic [FW-1:0]   r_frame;
  logic [CW-1:0]   r_cnt;
  logic [3:0][7:0] r_shd;
  logic [3:0][7:0] r_act;
  logic            r_ppm;
  logic            r_fs;
  logic            r_busy;
  logic [1:0]      r_ch;

  logic [3:0][7:0] w_ch_in;
  logic [7:0]      w_val;
  logic [SW-1:0]   w_slot;
  logic [CW-1:0]   w_mark_len;
  logic            w_tick;
  logic            w_sep_done;
  logic            w_mark_done;
  logic            w_frame_done;
  logic            w_entry;

  assign w_ch_in = {ch3_val, ch2_val, ch1_val, ch0_val};

  // Microsecond tick; prescaler is held at zero while idle.
  assign w_tick = (r_state != S_IDLE) && (r_presc == PW'(CLK_PER_US - 1));

  // Slot width 1000 + 4*val us; the mark is what remains after the separator.
  assign w_val      = r_act[r_ch];
  assign w_slot     = SW'(1000) + SW'({w_val, 2'b00});
  assign w_mark_len = CW'(w_slot) - CW'(SEP_US);

  assign w_sep_done   = w_tick && (r_cnt == CW'(SEP_US - 1));
  assign w_mark_done  = w_tick && (r_cnt == (w_mark_len - CW'(1)));
  assign w_frame_done = w_tick && (r_frame == FW'(FRAME_US - 1));

  // Frame entry happens from IDLE or at the end of GAP, whenever enable is set.
  assign w_entry = enable &&
                   ((r_state == S_IDLE) || ((r_state == S_GAP) && w_frame_done));

  // Shadow capture on upd; active set refreshed only on frame entry, taking the
  // live inputs when upd lands on the same cycle.
  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      r_shd <= '0;
      r_act <= '0;
    end else begin
      if (upd) begin
        r_shd <= w_ch_in;
      end
      if (w_entry) begin
        r_act <= upd ? w_ch_in : r_shd;
      end
    end
  end

  // Frame sequencing FSM with registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_frame <= '0;
      r_cnt   <= '0;
      r_ppm   <= LVL_HI;
      r_fs    <= 1'b0;
      r_busy  <= 1'b0;
      r_ch    <= '0;
    end else begin
      r_fs <= 1'b0;

      if (r_state == S_IDLE) begin
        r_presc <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      if (w_tick) begin
        r_frame <= r_frame + FW'(1);
        r_cnt   <= r_cnt + CW'(1);
      end

      if (w_entry) begin
        r_state <= S_SEP;
        r_fs    <= 1'b1;
        r_busy  <= 1'b1;
        r_ch    <= '0;
        r_ppm   <= LVL_LO;
        r_presc <= '0;
        r_frame <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_ppm  <= LVL_HI;
            r_busy <= 1'b0;
          end
          S_SEP: begin
            if (w_sep_done) begin
              r_state <= S_MARK;
              r_ppm   <= LVL_HI;
              r_cnt   <= '0;
            end
          end
          S_MARK: begin
            if (w_mark_done) begin
              r_ppm <= LVL_LO;
              r_cnt <= '0;
              if (r_ch != 2'd3) begin
                r_ch    <= r_ch + 2'd1;
                r_state <= S_SEP;
              end else begin
                r_state <= S_TAIL;
              end
            end
          end
          S_TAIL: begin
            if (w_sep_done) begin
              r_state <= S_GAP;
              r_ppm   <= LVL_HI;
              r_cnt   <= '0;
            end
          end
          S_GAP: begin
            // enable low here: frame has run its full length, fall back to idle.
            if (w_frame_done) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_ch    <= '0;
              r_ppm   <= LVL_HI;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ppm   <= LVL_HI;
          end
        endcase
      end
    end
  end

  assign ppm_out     = r_ppm;
  assign frame_start = r_fs;
  assign busy        = r_busy;
  assign ch_idx      = r_ch;

endmodule
